operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width.
REQ-002 The block SHALL have parameter NREG, default 32, register count; index width is 5.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset.
REQ-004 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instr is valid
- in_ready  out  1  stage accepts instr
- instr  in  32  RV32I instruction word
- flush  in  1  discard held and incoming instruction
- wb_en  in  1  writeback strobe
- wb_rd  in  5  writeback register index
- wb_data  in  XLEN  writeback value
- out_valid  out  1  ALU operands are valid
- out_ready  in  1  downstream consumes the operands
- valA  out  XLEN  ALU operand A
- valB  out  XLEN  ALU operand B
- operacion  out  4  ALU op code
- rd  out  5  destination register
- rd_we  out  1  destination write enable
- illegal  out  1  one-cycle pulse on an illegal instruction

Function
REQ-005 The block SHALL accept instr on the cycle where in_valid && in_ready && !flush.
REQ-006 in_ready SHALL equal !out_valid || out_ready.
REQ-007 Latency SHALL be 1 cycle: operands for an accepted instr appear with out_valid on the next edge.
REQ-008 While out_valid && !out_ready, valA, valB, operacion, rd and rd_we SHALL hold, except as REQ-015 requires.
REQ-009 R-type instructions (opcode 0110011) SHALL be decoded as follows:
- operacion = {instr[30], funct3}.
- valA = x[rs1], valB = x[rs2].
- Legal only for funct7=0000000 with any funct3, or funct7=0100000 with funct3 000 or 101.
REQ-010 I-ALU instructions (opcode 0010011) SHALL be decoded as follows:
- funct3 001/101: valB = zero-extended shamt instr[24:20]; operacion = {instr[30] if funct3=101 else 0, funct3}.
- Other funct3: valB = sign-extended instr[31:20]; operacion = {0, funct3}.
- valA = x[rs1].
REQ-011 LUI (opcode 0110111) SHALL produce valA=0, valB={instr[31:12],12'b0}, operacion=0000.
REQ-012 Any other opcode or illegal funct7 SHALL pulse illegal for 1 cycle, leave out_valid unasserted, and not change the register file.
REQ-013 Register x0 SHALL read 0, and writes to x0 SHALL be ignored.
REQ-014 On accept with wb_en, wb_rd==rs1 or rs2, and wb_rd!=0, the matching operand SHALL take wb_data (same-cycle bypass).
REQ-015 While held, a wb_en to a nonzero register that a register-sourced operand of the held instruction names SHALL update that operand to wb_data on the same edge.
REQ-016 The register file SHALL write wb_data to wb_rd on every edge with wb_en, independent of the handshake.
REQ-017 flush SHALL clear out_valid on the next edge, drop any instruction presented that cycle, and suppress illegal; it SHALL have priority over acceptance.
REQ-018 rd_we SHALL be 1 for every legal instruction with rd!=0, otherwise 0.

Reset
REQ-019 On reset assertion, the following SHALL be cleared immediately:
- out_valid=0, illegal=0, rd_we=0, rd=0.
- valA=0, valB=0, operacion=0000.
- All registers = 0.
REQ-020 An instruction in flight when reset is asserted SHALL be lost; the first edge after deassertion SHALL be able to accept.

Structure
REQ-021 A shared package SHALL hold:
- opcode constants (OP_R, OP_IMM, OP_LUI).
- The 4-bit ALU op codes: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
- XLEN.
REQ-022 The register file SHALL be one sub-module, reg_file, with 2 read ports and 1 write port and asynchronous reads.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
- Write x1=5, x2=3 via wb; add x3,x1,x2 -> next cycle valA=5, valB=3, operacion=0000, rd=3, rd_we=1.
- srai x4,x1,2 -> valB=2, operacion=1101; addi x5,x0,-1 -> valA=0, valB=FFFFFFFF, operacion=0000.
- Hold out_ready=0 with sub x6,x1,x2 held; wb x2=9 -> valB becomes 9 while out_valid stays 1; release -> in_ready=1 that cycle.
- Accept add x7,x1,x1 with wb x1=11 in the same cycle -> valA=valB=11; wb to x0 -> x0 still reads 0.
- Opcode 1111111 -> illegal pulses 1 cycle, out_valid=0; flush with in_valid=1 -> instruction dropped, out_valid=0 next cycle.
- Assert rst_n=0 mid-stall -> out_valid and all outputs 0 immediately, register file 0.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared constants and ALU op codes for operand fetch
package operand_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  // Shift-immediates carry a 5-bit shamt rather than a 12-bit immediate.
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == F3_SLL) || (funct3 == F3_SR);
  endfunction

endpackage

// File: rtl/operand_fetch_reg_file.sv
// rtl/operand_fetch_reg_file.sv - 2R1W register file, async reads, x0 hardwired to zero
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr_a_i,
  input  logic [4:0]      raddr_b_i,
  output logic [XLEN-1:0] rdata_a_o,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - decode RV32I ALU instructions and fetch operands into a 1-deep output stage
module operand_fetch #(
  parameter int XLEN = operand_fetch_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] valA,
  output logic [XLEN-1:0] valB,
  output logic [3:0]      operacion,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);
  import operand_fetch_pkg::*;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, dst;

  assign opcode = instr[6:0];
  assign dst    = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  logic [XLEN-1:0] rf_a, rf_b;

  reg_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wb_en),
    .waddr_i   (wb_rd),
    .wdata_i   (wb_data),
    .raddr_a_i (rs1),
    .raddr_b_i (rs2),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b)
  );

  logic            dec_legal, dec_a_reg, dec_b_reg;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_imm_b;

  always_comb begin
    dec_legal = 1'b0;
    dec_a_reg = 1'b0;
    dec_b_reg = 1'b0;
    dec_op    = ALU_ADD;
    dec_imm_b = '0;
    case (opcode)
      OP_R: begin
        dec_legal = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == F3_SR)));
        dec_a_reg = 1'b1;
        dec_b_reg = 1'b1;
        dec_op    = {instr[30], funct3};
      end
      OP_IMM: begin
        dec_legal = 1'b1;
        dec_a_reg = 1'b1;
        if (is_shift(funct3)) begin
          dec_imm_b = XLEN'(instr[24:20]);
          dec_op    = {(funct3 == F3_SR) ? instr[30] : 1'b0, funct3};
        end else begin
          dec_imm_b = XLEN'($signed(instr[31:20]));
          dec_op    = {1'b0, funct3};
        end
      end
      OP_LUI: begin
        dec_legal = 1'b1;
        dec_imm_b = XLEN'($signed({instr[31:12], 12'h000}));
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Same-cycle writeback bypass so an accepted instruction never sees a stale register.
  logic            wb_live;
  logic [XLEN-1:0] opnd_a, opnd_b;

  assign wb_live = wb_en && (wb_rd != 5'd0);
  assign opnd_a  = !dec_a_reg ? '0 : (wb_live && (wb_rd == rs1)) ? wb_data : rf_a;
  assign opnd_b  = !dec_b_reg ? dec_imm_b : (wb_live && (wb_rd == rs2)) ? wb_data : rf_b;

  logic            out_valid_q, illegal_q, rd_we_q, a_reg_q, b_reg_q;
  logic [XLEN-1:0] val_a_q, val_b_q;
  logic [3:0]      op_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic            accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      rd_we_q     <= 1'b0;
      rd_q        <= '0;
      val_a_q     <= '0;
      val_b_q     <= '0;
      op_q        <= ALU_ADD;
      rs1_q       <= '0;
      rs2_q       <= '0;
      a_reg_q     <= 1'b0;
      b_reg_q     <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= dec_legal;
        illegal_q   <= !dec_legal;
        if (dec_legal) begin
          val_a_q <= opnd_a;
          val_b_q <= opnd_b;
          op_q    <= dec_op;
          rd_q    <= dst;
          rd_we_q <= (dst != 5'd0);
          rs1_q   <= rs1;
          rs2_q   <= rs2;
          a_reg_q <= dec_a_reg;
          b_reg_q <= dec_b_reg;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end else if (out_valid_q && wb_live) begin
        // Held operands track writebacks to the registers they were read from.
        if (a_reg_q && (wb_rd == rs1_q)) val_a_q <= wb_data;
        if (b_reg_q && (wb_rd == rs2_q)) val_b_q <= wb_data;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign illegal   = illegal_q;
  assign valA      = val_a_q;
  assign valB      = val_b_q;
  assign operacion = op_q;
  assign rd        = rd_q;
  assign rd_we     = rd_we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed vectors, corner sequences and randomized model check of operand_fetch
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, wb_en, out_valid, out_ready, rd_we, illegal;
  logic [31:0] instr, wb_data, valA, valB;
  logic [4:0]  wb_rd, rd;
  logic [3:0]  operacion;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(32), .NREG(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .flush     (flush),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .valA      (valA),
    .valB      (valB),
    .operacion (operacion),
    .rd        (rd),
    .rd_we     (rd_we),
    .illegal   (illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ops(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [4:0] r, input logic we);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_valA"}, valA, a);
    chk({tag, "_valB"}, valB, b);
    chk({tag, "_op"}, 32'(operacion), 32'(op));
    chk({tag, "_rd"}, 32'(rd), 32'(r));
    chk({tag, "_rd_we"}, 32'(rd_we), 32'(we));
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {f7, rs2, rs1, f3, d, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {imm, rs1, f3, d, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] d);
    return {imm, d, 7'b0110111};
  endfunction

  typedef struct {
    logic [31:0] ins;
    bit          ill;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  r;
    bit          we;
  } vec_t;

  vec_t vecs[$];

  // Behavioural reference: register array plus the output stage contents.
  logic [31:0] m_regs [32];
  bit          m_valid, m_ill;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  bit          m_we;
  int          m_asrc, m_bsrc;

  function automatic void ref_decode(input logic [31:0] ins, output bit legal, output logic [3:0] op,
                                     output int a_src, output int b_src, output logic [31:0] imm);
    int f3;
    int imm12;
    f3    = int'(ins[14:12]);
    legal = 1'b1;
    op    = 4'd0;
    a_src = int'(ins[19:15]);
    b_src = -1;
    imm   = 32'd0;
    case (ins[6:0])
      7'b0110011: begin
        b_src = int'(ins[24:20]);
        legal = (ins[31:25] == 7'd0) || (ins[31:25] == 7'h20 && (f3 == 0 || f3 == 5));
        op    = 4'(int'(ins[30]) * 8 + f3);
      end
      7'b0010011: begin
        if (f3 == 1 || f3 == 5) begin
          imm = 32'(ins[24:20]);
          op  = 4'(((f3 == 5) ? int'(ins[30]) * 8 : 0) + f3);
        end else begin
          imm12 = int'(ins[31:20]);
          if (imm12 >= 2048) imm12 = imm12 - 4096;
          imm = 32'(imm12);
          op  = 4'(f3);
        end
      end
      7'b0110111: begin
        a_src = -1;
        imm   = 32'(ins[31:12]) * 32'd4096;
      end
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] read_src(input int src);
    if (src <= 0) return 32'd0;
    if (wb_en && int'(wb_rd) == src) return wb_data;
    return m_regs[src];
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 4);
    r[19:15] = 5'($urandom_range(0, 7));
    r[11:7]  = 5'($urandom_range(0, 7));
    case (k)
      0: begin
        r[6:0]   = 7'b0110011;
        r[24:20] = 5'($urandom_range(0, 7));
        if (r[31]) begin
          r[31:25] = 7'h20;
          r[14:12] = r[13] ? 3'd5 : 3'd0;
        end else r[31:25] = 7'h00;
      end
      1: begin
        r[6:0]   = 7'b0110011;
        r[24:20] = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          2: r[31:25] = 7'h01;
          default: ;
        endcase
      end
      2: r[6:0] = 7'b0010011;
      3: r[6:0] = 7'b0110111;
      default: ;
    endcase
    return r;
  endfunction

  task automatic idle_inputs();
    in_valid  = 1'b0;
    instr     = 32'd0;
    flush     = 1'b0;
    wb_en     = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'd0;
    out_ready = 1'b1;
  endtask

  task automatic do_wb(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_valA", valA, 32'd0);
    chk("rst_valB", valB, 32'd0);
    chk("rst_op", 32'(operacion), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_rd_we", 32'(rd_we), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    do_wb(5'd1, 32'd5);
    do_wb(5'd2, 32'd3);

    vecs.push_back('{enc_r(7'h00, 2, 1, 0, 3), 0, 32'd5, 32'd3, 4'h0, 5'd3, 1});
    vecs.push_back('{enc_i({7'h20, 5'd2}, 1, 5, 4), 0, 32'd5, 32'd2, 4'hD, 5'd4, 1});
    vecs.push_back('{enc_i(12'hFFF, 0, 0, 5), 0, 32'd0, 32'hFFFF_FFFF, 4'h0, 5'd5, 1});
    vecs.push_back('{enc_r(7'h20, 2, 1, 0, 6), 0, 32'd5, 32'd3, 4'h8, 5'd6, 1});
    vecs.push_back('{enc_u(20'hABCDE, 8), 0, 32'd0, 32'hABCD_E000, 4'h0, 5'd8, 1});
    vecs.push_back('{enc_i({7'h00, 5'd31}, 2, 1, 9), 0, 32'd3, 32'd31, 4'h1, 5'd9, 1});
    vecs.push_back('{enc_i(12'h004, 1, 5, 10), 0, 32'd5, 32'd4, 4'h5, 5'd10, 1});
    vecs.push_back('{enc_i(12'h7FF, 2, 7, 11), 0, 32'd3, 32'h7FF, 4'h7, 5'd11, 1});
    vecs.push_back('{enc_i(12'h800, 1, 4, 12), 0, 32'd5, 32'hFFFF_F800, 4'h4, 5'd12, 1});
    vecs.push_back('{enc_r(7'h00, 2, 1, 0, 0), 0, 32'd5, 32'd3, 4'h0, 5'd0, 0});
    vecs.push_back('{enc_r(7'h20, 2, 1, 5, 13), 0, 32'd5, 32'd3, 4'hD, 5'd13, 1});
    vecs.push_back('{enc_r(7'h00, 2, 1, 3, 14), 0, 32'd5, 32'd3, 4'h3, 5'd14, 1});
    vecs.push_back('{enc_i(12'h405, 2, 2, 15), 0, 32'd3, 32'h405, 4'h2, 5'd15, 1});
    vecs.push_back('{enc_r(7'h20, 2, 1, 1, 14), 1, 32'd0, 32'd0, 4'h0, 5'd0, 0});
    vecs.push_back('{enc_r(7'h01, 2, 1, 0, 15), 1, 32'd0, 32'd0, 4'h0, 5'd0, 0});
    vecs.push_back('{32'h0000_007F, 1, 32'd0, 32'd0, 4'h0, 5'd0, 0});

    foreach (vecs[i]) begin
      instr    = vecs[i].ins;
      in_valid = 1'b1;
      tick();
      if (vecs[i].ill) begin
        chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd0);
        chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'd1);
      end else begin
        chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'd0);
        chk_ops($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].r, vecs[i].we);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("illegal_pulse_end", 32'(illegal), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Stall with a writeback to a held source register, then release.
    instr = enc_r(7'h20, 2, 1, 0, 6); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    chk_ops("held", 32'd5, 32'd3, 4'h8, 5'd6, 1);
    instr = enc_r(7'h00, 2, 1, 0, 3);
    wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'd9;
    #1 chk("held_in_ready", 32'(in_ready), 32'd0);
    tick();
    wb_en = 1'b0;
    chk_ops("held_upd", 32'd5, 32'd9, 4'h8, 5'd6, 1);
    out_ready = 1'b1;
    #1 chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_ops("after_release", 32'd5, 32'd9, 4'h0, 5'd3, 1);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Accept-time bypass, then writes to x0.
    instr = enc_r(7'h00, 1, 1, 0, 7); in_valid = 1'b1;
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd11;
    tick();
    chk_ops("bypass", 32'd11, 32'd11, 4'h0, 5'd7, 1);
    instr = enc_r(7'h00, 0, 0, 0, 15);
    wb_rd = 5'd0; wb_data = 32'd77;
    tick();
    wb_en = 1'b0;
    chk_ops("x0_bypass", 32'd0, 32'd0, 4'h0, 5'd15, 1);
    instr = enc_r(7'h00, 0, 0, 0, 16);
    tick();
    chk_ops("x0_read", 32'd0, 32'd0, 4'h0, 5'd16, 1);

    // Flush beats acceptance and suppresses illegal.
    instr = enc_r(7'h00, 2, 1, 0, 3); flush = 1'b1;
    tick();
    chk("flush_valid", 32'(out_valid), 32'd0);
    instr = 32'h0000_007F;
    tick();
    chk("flush_valid_ill", 32'(out_valid), 32'd0);
    chk("flush_illegal", 32'(illegal), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();

    // Asynchronous reset in the middle of a stall.
    instr = enc_r(7'h20, 2, 1, 0, 6); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    chk("prerst_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_valA", valA, 32'd0);
    chk("arst_valB", valB, 32'd0);
    chk("arst_op", 32'(operacion), 32'd0);
    chk("arst_rd", 32'(rd), 32'd0);
    chk("arst_rd_we", 32'(rd_we), 32'd0);
    chk("arst_illegal", 32'(illegal), 32'd0);
    tick();
    rst_n = 1'b1;
    instr = enc_r(7'h00, 2, 1, 0, 3); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk_ops("post_rst", 32'd0, 32'd0, 4'h0, 5'd3, 1);

    // Randomized run against the reference model from a clean reset.
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit          legal, exp_ready;
      logic [3:0]  op;
      int          asrc, bsrc;
      logic [31:0] imm;
      in_valid  = ($urandom_range(0, 3) != 0);
      instr     = gen_instr();
      out_ready = 1'($urandom_range(0, 1));
      wb_en     = 1'($urandom_range(0, 1));
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      #1;
      exp_ready = !m_valid || out_ready;
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
      m_ill = 1'b0;
      if (flush) m_valid = 1'b0;
      else if (in_valid && exp_ready) begin
        ref_decode(instr, legal, op, asrc, bsrc, imm);
        if (legal) begin
          m_valid = 1'b1;
          m_a     = read_src(asrc);
          m_b     = (bsrc >= 0) ? read_src(bsrc) : imm;
          m_op    = op;
          m_rd    = instr[11:7];
          m_we    = (instr[11:7] != 5'd0);
          m_asrc  = asrc;
          m_bsrc  = bsrc;
        end else begin
          m_valid = 1'b0;
          m_ill   = 1'b1;
        end
      end else if (m_valid && out_ready) m_valid = 1'b0;
      else if (m_valid && wb_en && wb_rd != 5'd0) begin
        if (m_asrc == int'(wb_rd)) m_a = wb_data;
        if (m_bsrc == int'(wb_rd)) m_b = wb_data;
      end
      if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
      tick();
      chk("rnd_valid", 32'(out_valid), 32'(m_valid));
      chk("rnd_illegal", 32'(illegal), 32'(m_ill));
      if (m_valid) chk_ops("rnd", m_a, m_b, m_op, m_rd, m_we);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
